sensor_scan_display: RTL

SENSOR_SCAN_DISPLAY -- requirements
Module: sensor_scan_display

---
 rtl/sensor_scan_display.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/sensor_scan_display.sv
// Periodic multi-channel sensor scanner: requests one sample per channel, tracks
// value/min/max/alarm/stale per channel and renders the selected channel as two ASCII lines.
module sensor_scan_display #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned THRESH   = 200,
    localparam int unsigned CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_req,
    output logic [CW-1:0]     o_ch,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CW-1:0]     i_sel,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_display,
    output logic [N_CH-1:0]   o_alarm,
    output logic [N_CH-1:0]   o_stale,
    output logic              o_busy,
    output logic [127:0]      o_txt_line1,
    output logic [127:0]      o_txt_line2
);

    localparam int unsigned TKW = $clog2(TICK_DIV);
    localparam int unsigned TOW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW  = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] TH = DATA_W'(THRESH);
    localparam logic [127:0] BLANK = {16{8'h20}};

    typedef enum logic [2:0] {IDLE, REQ, NEXT, FORMAT, UPDATE} state_t;

    state_t              state_q, state_d;
    logic [TKW-1:0]      tick_cnt_q;
    logic                tick;
    logic [CW-1:0]       ch_q, ch_d;
    logic [CW-1:0]       sel_q, sel_d;
    logic [TOW-1:0]      to_q, to_d;
    logic [DATA_W-1:0]   val_q [N_CH];
    logic [DATA_W-1:0]   min_q [N_CH];
    logic [DATA_W-1:0]   max_q [N_CH];
    logic [N_CH-1:0]     alarm_q, stale_q;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [15:0]         bcd_q, bcd_d, bcd_adj, bcd_sh;
    logic [BW-1:0]       bit_q, bit_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         dig_val_q, dig_min_q, dig_max_q;
    logic [127:0]        txt1_q, txt2_q;
    logic [DATA_W-1:0]   disp_q;
    logic                store_en, timeout_hit, conv_done;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    function automatic logic [31:0] d4(input logic [15:0] b);
        return {asc(b[15:12]), asc(b[11:8]), asc(b[7:4]), asc(b[3:0])};
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int unsigned k = 0; k < 4; k++) begin
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign tick      = (tick_cnt_q == TKW'(TICK_DIV - 1));
    assign bcd_adj   = add3(bcd_q);
    assign bcd_sh    = (bcd_adj << 1) | 16'(bin_q[DATA_W-1]);
    assign o_ch      = ch_q;
    assign o_busy    = (state_q != IDLE);
    assign o_display = disp_q;
    assign o_alarm   = alarm_q;
    assign o_stale   = stale_q;
    assign o_txt_line1 = txt1_q;
    assign o_txt_line2 = txt2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        sel_d       = sel_q;
        to_d        = to_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        store_en    = 1'b0;
        timeout_hit = 1'b0;
        conv_done   = 1'b0;
        o_req       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = REQ;
                    ch_d    = '0;
                    to_d    = '0;
                end
            end
            REQ: begin
                o_req = 1'b1;
                if (i_valid) begin
                    store_en = 1'b1;
                    state_d  = NEXT;
                end else if (to_q == TOW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = NEXT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            NEXT: begin
                if (ch_q < CW'(N_CH - 1)) begin
                    ch_d    = ch_q + 1'b1;
                    to_d    = '0;
                    state_d = REQ;
                end else begin
                    sel_d   = (32'(i_sel) >= N_CH) ? '0 : i_sel;
                    bin_d   = val_q[sel_d];
                    bcd_d   = '0;
                    bit_d   = '0;
                    idx_d   = 2'd0;
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                bcd_d = bcd_sh;
                bin_d = bin_q << 1;
                bit_d = bit_q + 1'b1;
                // Each finished conversion immediately preloads the next operand (min, then max).
                if (bit_q == BW'(DATA_W - 1)) begin
                    conv_done = 1'b1;
                    bit_d     = '0;
                    bcd_d     = '0;
                    idx_d     = idx_q + 2'd1;
                    bin_d     = (idx_q == 2'd0) ? min_q[sel_q] : max_q[sel_q];
                    if (idx_q == 2'd2) state_d = UPDATE;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt_q <= '0;
            ch_q       <= '0;
            sel_q      <= '0;
            to_q       <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            dig_val_q  <= '0;
            dig_min_q  <= '0;
            dig_max_q  <= '0;
            alarm_q    <= '0;
            stale_q    <= '0;
            disp_q     <= '0;
            txt1_q     <= BLANK;
            txt2_q     <= BLANK;
            for (int unsigned i = 0; i < N_CH; i++) begin
                val_q[i] <= '0;
                min_q[i] <= '1;
                max_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            ch_q  <= ch_d;
            sel_q <= sel_d;
            to_q  <= to_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            bit_q <= bit_d;
            idx_q <= idx_d;
            // A clear and a store in the same cycle leave min = max = the new sample.
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (i_clr) begin
                    min_q[i] <= '1;
                    max_q[i] <= '0;
                end
                if (store_en && ch_q == CW'(i)) begin
                    val_q[i]   <= i_data;
                    alarm_q[i] <= (i_data >= TH);
                    stale_q[i] <= 1'b0;
                    min_q[i]   <= (i_clr || i_data < min_q[i]) ? i_data : min_q[i];
                    max_q[i]   <= (i_clr || i_data > max_q[i]) ? i_data : max_q[i];
                end
                if (timeout_hit && ch_q == CW'(i)) stale_q[i] <= 1'b1;
            end
            if (conv_done) begin
                case (idx_q)
                    2'd0:    dig_val_q <= bcd_sh;
                    2'd1:    dig_min_q <= bcd_sh;
                    default: dig_max_q <= bcd_sh;
                endcase
            end
            if (state_q == UPDATE) begin
                disp_q <= val_q[sel_q];
                txt1_q <= {"CH", asc(4'(sel_q)), " VAL=", d4(dig_val_q), "   ",
                           stale_q[sel_q] ? "?" : (alarm_q[sel_q] ? "!" : " ")};
                txt2_q <= {"L ", d4(dig_min_q), "  H ", d4(dig_max_q), "  "};
            end
        end
    end

endmodule
